// File: rtl/pe_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the PE array loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_pkg;

  localparam int WEIGHT_WIDTH_DEF = 1;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int KERNEL_SIZE_DEF  = 2;
  localparam int TIMEOUT_DEF      = 255;

  // Derived from the defaults; the loader recomputes these from its own parameters
  localparam int KERNEL_DIM_DEF   = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int RESULT_WIDTH_DEF = DATA_WIDTH_DEF + WEIGHT_WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FILL   = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/pe_window_packer.sv
// Packs serially accepted pixels into one window, first pixel in the MSB slot.
// Latency: a pushed pixel is visible in o_window one cycle after the push edge.
// Backpressure: pushes are ignored once full; the owner gates i_push with its ready.
module pe_window_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 4,
  localparam int CW = $clog2(KERNEL_DIM + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_clr,
  input  logic                             i_push,
  input  logic [DATA_WIDTH-1:0]            i_pix,
  output logic [DATA_WIDTH*KERNEL_DIM-1:0] o_window,
  output logic [CW-1:0]                    o_count,
  output logic                             o_full
);

  logic [DATA_WIDTH*KERNEL_DIM-1:0] r_window;
  logic [CW-1:0]                    r_count;
  logic                             w_full;

  assign w_full   = (r_count == CW'(KERNEL_DIM));
  assign o_window = r_window;
  assign o_count  = r_count;
  assign o_full   = w_full;

  // Slot k (counted from the first accepted pixel) lands at the k-th slot from the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_window <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_window <= '0;
      r_count  <= '0;
    end else if (i_push && !w_full) begin
      for (int k = 0; k < KERNEL_DIM; k++) begin
        if (r_count == CW'(k)) begin
          r_window[(KERNEL_DIM-k)*DATA_WIDTH-1 -: DATA_WIDTH] <= i_pix;
        end
      end
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/pe_array_loader.sv
// Loads weights into pe_array, streams packed pixel windows in, captures results.
// Latency: wr_dataIn_en rises one cycle after the last pixel of a window is accepted.
// Backpressure: pix_ready stays low until the held result is taken (result_valid & result_ready).
module pe_array_loader
  import pe_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  localparam int KERNEL_DIM   = KERNEL_SIZE * KERNEL_SIZE,
  localparam int RESULT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WEIGHT_WIDTH*KERNEL_DIM-1:0] weight_in,
  input  logic                               weight_load,
  input  logic                               pix_valid,
  input  logic [DATA_WIDTH-1:0]              pix_data,
  output logic                               pix_ready,
  output logic [WEIGHT_WIDTH*KERNEL_DIM-1:0] weight_array,
  output logic                               wr_weight_en,
  input  logic                               wr_weight_done,
  output logic [DATA_WIDTH*KERNEL_DIM-1:0]   dataIn,
  output logic                               wr_dataIn_en,
  input  logic                               pe_array_done,
  input  logic [RESULT_WIDTH*KERNEL_SIZE-1:0] dataOut,
  output logic                               result_valid,
  output logic [RESULT_WIDTH*KERNEL_SIZE-1:0] result_data,
  input  logic                               result_ready,
  output logic                               weights_loaded,
  output logic                               timeout_err
);

  localparam int CW = $clog2(KERNEL_DIM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                             r_state;
  logic [WEIGHT_WIDTH*KERNEL_DIM-1:0] r_weight_array;
  logic [WEIGHT_WIDTH*KERNEL_DIM-1:0] r_shadow;
  logic                               r_load_pending;
  logic                               r_wr_weight_en;
  logic                               r_wr_data_en;
  logic                               r_result_valid;
  logic [RESULT_WIDTH*KERNEL_SIZE-1:0] r_result_data;
  logic                               r_weights_loaded;
  logic                               r_timeout_err;
  logic [TW-1:0]                      r_tmo;

  logic [CW-1:0]                      w_count;
  logic                               w_full;
  logic                               w_push;
  logic                               w_last;
  logic                               w_reload_now;
  logic                               w_xfer;
  logic                               w_waiting;
  logic                               w_tmo_hit;
  logic                               w_clr;
  logic [WEIGHT_WIDTH*KERNEL_DIM-1:0] w_next_weights;

  // A reload is only allowed to start between windows; a fresh request beats an older pending one
  assign w_reload_now   = (r_state == FILL) && (w_count == '0) && (weight_load || r_load_pending);
  assign w_next_weights = weight_load ? weight_in : r_shadow;
  assign pix_ready      = (r_state == FILL) && !w_full && !w_reload_now;
  assign w_push         = pix_valid && pix_ready;
  assign w_last         = w_push && (w_count == CW'(KERNEL_DIM - 1));
  assign w_xfer         = (r_state == DRAIN) && r_result_valid && result_ready;
  assign w_waiting      = ((r_state == LOAD_W) && !wr_weight_done) ||
                          ((r_state == RUN) && !pe_array_done);
  assign w_tmo_hit      = w_waiting && (r_tmo == TW'(TIMEOUT - 1));
  // The window is discarded once its result is handed on, or when a run times out
  assign w_clr          = w_xfer || ((r_state == RUN) && w_tmo_hit);

  pe_window_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL_DIM (KERNEL_DIM)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_push   (w_push),
    .i_pix    (pix_data),
    .o_window (dataIn),
    .o_count  (w_count),
    .o_full   (w_full)
  );

  assign weight_array   = r_weight_array;
  assign wr_weight_en   = r_wr_weight_en;
  assign wr_dataIn_en   = r_wr_data_en;
  assign result_valid   = r_result_valid;
  assign result_data    = r_result_data;
  assign weights_loaded = r_weights_loaded;
  assign timeout_err    = r_timeout_err;

  // Control FSM: weight load handshake, window run, result hold and timeout watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_weight_array   <= '0;
      r_shadow         <= '0;
      r_load_pending   <= 1'b0;
      r_wr_weight_en   <= 1'b0;
      r_wr_data_en     <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_data    <= '0;
      r_weights_loaded <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_tmo            <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (weight_load) begin
            r_weight_array   <= weight_in;
            r_load_pending   <= 1'b0;
            r_wr_weight_en   <= 1'b1;
            r_weights_loaded <= 1'b0;
            r_tmo            <= '0;
            r_state          <= LOAD_W;
          end
        end

        LOAD_W: begin
          // weight_array must stay stable while pe_array is writing it
          if (weight_load) begin
            r_shadow       <= weight_in;
            r_load_pending <= 1'b1;
          end
          if (wr_weight_done) begin
            r_wr_weight_en   <= 1'b0;
            r_weights_loaded <= 1'b1;
            r_state          <= FILL;
          end else if (w_tmo_hit) begin
            r_wr_weight_en   <= 1'b0;
            r_weights_loaded <= 1'b0;
            r_timeout_err    <= 1'b1;
            r_state          <= IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        FILL: begin
          if (w_reload_now) begin
            r_weight_array   <= w_next_weights;
            r_load_pending   <= 1'b0;
            r_wr_weight_en   <= 1'b1;
            r_weights_loaded <= 1'b0;
            r_tmo            <= '0;
            r_state          <= LOAD_W;
          end else begin
            if (weight_load) begin
              r_shadow       <= weight_in;
              r_load_pending <= 1'b1;
            end
            if (w_last) begin
              r_wr_data_en <= 1'b1;
              r_tmo        <= '0;
              r_state      <= RUN;
            end
          end
        end

        RUN: begin
          if (weight_load) begin
            r_shadow       <= weight_in;
            r_load_pending <= 1'b1;
          end
          if (pe_array_done) begin
            r_result_data  <= dataOut;
            r_result_valid <= 1'b1;
            r_wr_data_en   <= 1'b0;
            r_state        <= DRAIN;
          end else if (w_tmo_hit) begin
            r_wr_data_en     <= 1'b0;
            r_weights_loaded <= 1'b0;
            r_timeout_err    <= 1'b1;
            r_state          <= IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        DRAIN: begin
          if (w_xfer) begin
            r_result_valid <= 1'b0;
            if (r_load_pending || weight_load) begin
              r_weight_array   <= w_next_weights;
              r_load_pending   <= 1'b0;
              r_wr_weight_en   <= 1'b1;
              r_weights_loaded <= 1'b0;
              r_tmo            <= '0;
              r_state          <= LOAD_W;
            end else begin
              r_state <= FILL;
            end
          end else if (weight_load) begin
            r_shadow       <= weight_in;
            r_load_pending <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_loader.sv
// Directed bench for pe_array_loader with a bench-driven pe_array stub.
// Latency: checks the one-cycle window-to-enable latency and the 255-cycle timeout.
// Backpressure: holds result_ready low and checks the loader stalls the pixel stream.
module tb_pe_array_loader;
  import pe_pkg::*;

  localparam logic [17:0] RES1 = {9'd6, 9'd8};
  localparam logic [17:0] RES2 = {9'd3, 9'd5};
  localparam logic [17:0] RES3 = {9'd1, 9'd2};

  logic        clk;
  logic        rst;
  logic [3:0]  weight_in;
  logic        weight_load;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [3:0]  weight_array;
  logic        wr_weight_en;
  logic        wr_weight_done;
  logic [31:0] dataIn;
  logic        wr_dataIn_en;
  logic        pe_array_done;
  logic [17:0] dataOut;
  logic        result_valid;
  logic [17:0] result_data;
  logic        result_ready;
  logic        weights_loaded;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  pe_array_loader dut (
    .clk            (clk),
    .rst            (rst),
    .weight_in      (weight_in),
    .weight_load    (weight_load),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .weight_array   (weight_array),
    .wr_weight_en   (wr_weight_en),
    .wr_weight_done (wr_weight_done),
    .dataIn         (dataIn),
    .wr_dataIn_en   (wr_dataIn_en),
    .pe_array_done  (pe_array_done),
    .dataOut        (dataOut),
    .result_valid   (result_valid),
    .result_data    (result_data),
    .result_ready   (result_ready),
    .weights_loaded (weights_loaded),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted; pix_valid stays high afterwards
  task automatic send_pix(input logic [7:0] p);
    int n;
    pix_valid = 1'b1;
    pix_data  = p;
    n = 0;
    while (!pix_ready && n < 50) begin
      tick();
      n++;
    end
    check_val("pix_ready_wait", pix_ready, 1);
    tick();
  endtask

  // Weight load from IDLE or an empty FILL, then the stub acknowledges it
  task automatic load_weights(input logic [3:0] w);
    weight_in   = w;
    weight_load = 1'b1;
    tick();
    weight_load = 1'b0;
    check_val("wload_en", wr_weight_en, 1);
    check_val("wload_arr", weight_array, w);
    ack_weights();
  endtask

  task automatic ack_weights();
    tick();
    wr_weight_done = 1'b1;
    tick();
    wr_weight_done = 1'b0;
    check_val("wdone_en_low", wr_weight_en, 0);
    check_val("wdone_loaded", weights_loaded, 1);
  endtask

  // Stub pe_array finishes the run with a fixed result, then drives junk on dataOut
  task automatic finish_run(input logic [17:0] res);
    int n;
    n = 0;
    while (!wr_dataIn_en && n < 50) begin
      tick();
      n++;
    end
    check_val("run_en_wait", wr_dataIn_en, 1);
    tick();
    dataOut       = res;
    pe_array_done = 1'b1;
    tick();
    pe_array_done = 1'b0;
    dataOut       = 18'h3ffff;
    check_val("res_valid", result_valid, 1);
    check_val("res_data", result_data, res);
    check_val("run_en_low", wr_dataIn_en, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    weight_in      = '0;
    weight_load    = 1'b0;
    pix_valid      = 1'b0;
    pix_data       = '0;
    wr_weight_done = 1'b0;
    pe_array_done  = 1'b0;
    dataOut        = '0;
    result_ready   = 1'b0;
    #12;
    check_val("rst_ctrl", {pix_ready, wr_weight_en, wr_dataIn_en, result_valid,
                           weights_loaded, timeout_err}, 0);
    check_val("rst_data", {weight_array, dataIn, result_data}, 0);
    check_val("rst_state", dut.r_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_val("idle_pix_ready", pix_ready, 0);

    // Basic window: weights 1111, pixels 1..4 back to back
    load_weights(4'b1111);
    send_pix(8'd1);
    send_pix(8'd2);
    send_pix(8'd3);
    send_pix(8'd4);
    check_val("full_drop", pix_ready, 0);
    check_val("lat_en", wr_dataIn_en, 1);
    check_val("win1", dataIn, 32'h01020304);
    pix_valid = 1'b0;
    finish_run(RES1);

    // Backpressure: result held 10 cycles while the next pixel waits
    pix_valid = 1'b1;
    pix_data  = 8'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_hold", {pix_ready, result_valid, result_data}, {1'b0, 1'b1, RES1});
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_val("bp_xfer_valid", result_valid, 0);
    check_val("bp_next_ready", pix_ready, 1);

    // Pending reload requested during RUN
    send_pix(8'd5);
    send_pix(8'd6);
    send_pix(8'd7);
    send_pix(8'd8);
    pix_valid = 1'b0;
    check_val("win2", dataIn, 32'h05060708);
    weight_in   = 4'b0101;
    weight_load = 1'b1;
    tick();
    weight_load = 1'b0;
    check_val("pend_arr_held", weight_array, 4'b1111);
    check_val("pend_win_held", dataIn, 32'h05060708);
    check_val("pend_no_wen", wr_weight_en, 0);
    // result_ready already high when result_valid rises: no transfer that edge
    result_ready  = 1'b1;
    dataOut       = RES2;
    pe_array_done = 1'b1;
    tick();
    pe_array_done = 1'b0;
    check_val("rdy_same_cycle", result_valid, 1);
    check_val("res2_data", result_data, RES2);
    tick();
    result_ready = 1'b0;
    check_val("pend_xfer", result_valid, 0);
    check_val("pend_loadw", wr_weight_en, 1);
    check_val("pend_arr_new", weight_array, 4'b0101);
    check_val("pend_no_pix", pix_ready, 0);
    ack_weights();

    // Collision: weight_load and a pixel together in an empty FILL
    pix_valid   = 1'b1;
    pix_data    = 8'hAA;
    weight_in   = 4'b0011;
    weight_load = 1'b1;
    #1;
    check_val("coll_ready", pix_ready, 0);
    tick();
    weight_load = 1'b0;
    check_val("coll_loadw", wr_weight_en, 1);
    check_val("coll_arr", weight_array, 4'b0011);
    check_val("coll_cnt", dut.u_packer.o_count, 0);
    ack_weights();
    send_pix(8'hAA);
    send_pix(8'h01);
    send_pix(8'h02);
    send_pix(8'h03);
    pix_valid = 1'b0;
    check_val("win3", dataIn, 32'hAA010203);
    finish_run(RES3);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_val("win3_xfer", result_valid, 0);

    // Async reset between edges after two pixels
    send_pix(8'h11);
    send_pix(8'h22);
    pix_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_ctrl", {pix_ready, wr_weight_en, wr_dataIn_en, result_valid,
                            weights_loaded, timeout_err}, 0);
    check_val("arst_data", {weight_array, dataIn, result_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    load_weights(4'b1111);
    send_pix(8'd9);
    send_pix(8'd8);
    send_pix(8'd7);
    send_pix(8'd6);
    pix_valid = 1'b0;
    check_val("win4", dataIn, 32'h09080706);

    // Timeout: stub never acknowledges the weight load
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    weight_in   = 4'b1010;
    weight_load = 1'b1;
    tick();
    weight_load = 1'b0;
    check_val("tmo_en", wr_weight_en, 1);
    repeat (254) tick();
    check_val("tmo_early", {timeout_err, wr_weight_en}, 2'b01);
    tick();
    check_val("tmo_err", timeout_err, 1);
    check_val("tmo_en_low", wr_weight_en, 0);
    check_val("tmo_loaded", weights_loaded, 0);
    check_val("tmo_state", dut.r_state, IDLE);
    tick();
    check_val("tmo_sticky", timeout_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
